// File: rtl/conv_pe_ctrl.sv
// Pass sequencer for one ConvPE convolution over a single input channel.
// It loads the kernel weights, streams the feature map and collects the PE results into the output buffer.
module conv_pe_ctrl #(
  parameter int DWIDTH        = 16,
  parameter int KERNEL_SIZE   = 3,
  parameter int AWIDTH        = 10,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4:0]        featmap_size,
  input  logic [AWIDTH-1:0] w_base,
  input  logic [AWIDTH-1:0] f_base,
  input  logic [AWIDTH-1:0] o_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              w_rd_en,
  output logic [AWIDTH-1:0] w_addr,
  input  logic [DWIDTH-1:0] w_data,
  output logic              f_rd_en,
  output logic [AWIDTH-1:0] f_addr,
  input  logic [DWIDTH-1:0] f_data,
  output logic              pe_win_st,
  output logic [DWIDTH-1:0] pe_win,
  output logic [DWIDTH-1:0] pe_din,
  output logic              pe_input_rd_en,
  output logic [4:0]        pe_featmap_size,
  output logic              pe_convlayer_state,
  input  logic [DWIDTH-1:0] pe_dout,
  input  logic              pe_dout_start,
  output logic              o_wr_en,
  output logic [AWIDTH-1:0] o_addr,
  output logic [DWIDTH-1:0] o_data
);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  localparam int              TW      = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [4:0]      K5      = 5'(KERNEL_SIZE);
  localparam logic [9:0]      KSQ     = 10'(KERNEL_SIZE * KERNEL_SIZE);
  localparam logic [TW-1:0]   TO_LAST = TW'(DRAIN_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [4:0]        n_q, n_d;
  logic [AWIDTH-1:0] f_base_q, f_base_d, o_base_q, o_base_d;
  logic [9:0]        cnt_q, cnt_d, k_q, k_d;
  logic [TW-1:0]     tc_q, tc_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              w_rd_en_q, w_rd_en_d, f_rd_en_q, f_rd_en_d;
  logic [AWIDTH-1:0] w_addr_q, w_addr_d, f_addr_q, f_addr_d, o_addr_q, o_addr_d;
  logic              pe_win_st_q, pe_win_st_d, pe_input_rd_en_q, pe_input_rd_en_d;
  logic              conv_q, conv_d, o_wr_en_q, o_wr_en_d;
  logic [DWIDTH-1:0] o_data_q, o_data_d;

  logic [4:0] r_edge;
  logic [9:0] n_sq, r_cnt;

  assign r_edge = n_q - K5 + 5'd1;
  assign n_sq   = 10'(n_q) * 10'(n_q);
  assign r_cnt  = 10'(r_edge) * 10'(r_edge);

  always_comb begin
    state_d          = state_q;
    n_d              = n_q;
    f_base_d         = f_base_q;
    o_base_d         = o_base_q;
    cnt_d            = cnt_q;
    k_d              = k_q;
    tc_d             = tc_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    err_d            = err_q;
    w_rd_en_d        = 1'b0;
    w_addr_d         = w_addr_q;
    f_rd_en_d        = 1'b0;
    f_addr_d         = f_addr_q;
    o_wr_en_d        = 1'b0;
    o_addr_d         = o_addr_q;
    o_data_d         = o_data_q;
    pe_win_st_d      = w_rd_en_q;
    pe_input_rd_en_d = f_rd_en_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d      = featmap_size;
          f_base_d = f_base;
          o_base_d = o_base;
          if (featmap_size < K5 || featmap_size == 5'd0) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d     = 1'b0;
            busy_d    = 1'b1;
            state_d   = LOAD_W;
            w_rd_en_d = 1'b1;
            w_addr_d  = w_base;
            cnt_d     = 10'd1;
            k_d       = '0;
          end
        end
      end
      LOAD_W: begin
        // cnt_q counts reads already issued; the final weight read hands straight over to the pixel stream
        if (cnt_q == KSQ) begin
          state_d   = STREAM;
          f_rd_en_d = 1'b1;
          f_addr_d  = f_base_q;
          cnt_d     = 10'd1;
        end else begin
          w_rd_en_d = 1'b1;
          w_addr_d  = w_addr_q + AWIDTH'(1);
          cnt_d     = cnt_q + 10'd1;
        end
      end
      STREAM: begin
        if (cnt_q == n_sq) begin
          state_d = DRAIN;
          tc_d    = '0;
        end else begin
          f_rd_en_d = 1'b1;
          f_addr_d  = f_addr_q + AWIDTH'(1);
          cnt_d     = cnt_q + 10'd1;
        end
      end
      DRAIN: tc_d = tc_q + TW'(1);
      default: state_d = IDLE;
    endcase

    if ((state_q == STREAM || state_q == DRAIN) && pe_dout_start && k_q < r_cnt) begin
      o_wr_en_d = 1'b1;
      o_addr_d  = o_base_q + AWIDTH'(k_q);
      o_data_d  = pe_dout;
      k_d       = k_q + 10'd1;
    end

    // Counting this cycle's result lets the last write and done land together
    if (state_q == DRAIN) begin
      if (k_d == r_cnt) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end else if (tc_q == TO_LAST) begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end

    conv_d = (state_d == STREAM) || (state_d == DRAIN) || pe_input_rd_en_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      n_q              <= '0;
      f_base_q         <= '0;
      o_base_q         <= '0;
      cnt_q            <= '0;
      k_q              <= '0;
      tc_q             <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      w_rd_en_q        <= 1'b0;
      w_addr_q         <= '0;
      f_rd_en_q        <= 1'b0;
      f_addr_q         <= '0;
      o_wr_en_q        <= 1'b0;
      o_addr_q         <= '0;
      o_data_q         <= '0;
      pe_win_st_q      <= 1'b0;
      pe_input_rd_en_q <= 1'b0;
      conv_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      n_q              <= n_d;
      f_base_q         <= f_base_d;
      o_base_q         <= o_base_d;
      cnt_q            <= cnt_d;
      k_q              <= k_d;
      tc_q             <= tc_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      err_q            <= err_d;
      w_rd_en_q        <= w_rd_en_d;
      w_addr_q         <= w_addr_d;
      f_rd_en_q        <= f_rd_en_d;
      f_addr_q         <= f_addr_d;
      o_wr_en_q        <= o_wr_en_d;
      o_addr_q         <= o_addr_d;
      o_data_q         <= o_data_d;
      pe_win_st_q      <= pe_win_st_d;
      pe_input_rd_en_q <= pe_input_rd_en_d;
      conv_q           <= conv_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;
  assign w_rd_en            = w_rd_en_q;
  assign w_addr             = w_addr_q;
  assign f_rd_en            = f_rd_en_q;
  assign f_addr             = f_addr_q;
  // Buffer data is passed through only while its strobe is up, so idle/reset shows zero
  assign pe_win_st          = pe_win_st_q;
  assign pe_win             = pe_win_st_q ? w_data : '0;
  assign pe_input_rd_en     = pe_input_rd_en_q;
  assign pe_din             = pe_input_rd_en_q ? f_data : '0;
  assign pe_featmap_size    = n_q;
  assign pe_convlayer_state = conv_q;
  assign o_wr_en            = o_wr_en_q;
  assign o_addr             = o_addr_q;
  assign o_data             = o_data_q;

endmodule

// File: tb/tb_conv_pe_ctrl.sv
// Bench for conv_pe_ctrl: buffer models, a ConvPE result stub, a per-pass vector table and
// hand-written reset / stray-input sequences.
module tb_conv_pe_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [4:0]  featmap_size;
  logic [9:0]  w_base, f_base, o_base;
  logic        busy, done, err;
  logic        w_rd_en, f_rd_en, o_wr_en;
  logic [9:0]  w_addr, f_addr, o_addr;
  logic [15:0] w_data, f_data, o_data;
  logic        pe_win_st, pe_input_rd_en, pe_convlayer_state, pe_dout_start;
  logic [15:0] pe_win, pe_din, pe_dout;
  logic [4:0]  pe_featmap_size;

  logic [15:0] wmem [0:1023];
  logic [15:0] fmem [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0] n;
    logic [9:0] wb, fb, ob;
    int         limit;
    int         exp_w, exp_f, exp_wr;
    logic       exp_err;
    int         exp_lat, exp_cs;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  conv_pe_ctrl #(.DWIDTH(16), .KERNEL_SIZE(3), .AWIDTH(10), .DRAIN_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .start(start), .featmap_size(featmap_size),
    .w_base(w_base), .f_base(f_base), .o_base(o_base),
    .busy(busy), .done(done), .err(err),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
    .f_rd_en(f_rd_en), .f_addr(f_addr), .f_data(f_data),
    .pe_win_st(pe_win_st), .pe_win(pe_win), .pe_din(pe_din),
    .pe_input_rd_en(pe_input_rd_en), .pe_featmap_size(pe_featmap_size),
    .pe_convlayer_state(pe_convlayer_state), .pe_dout(pe_dout),
    .pe_dout_start(pe_dout_start),
    .o_wr_en(o_wr_en), .o_addr(o_addr), .o_data(o_data)
  );

  // Registered-read buffer models
  always @(posedge clk) begin
    if (w_rd_en) w_data <= wmem[w_addr];
    if (f_rd_en) f_data <= fmem[f_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs_or();
    return int'(|{busy, done, err, w_rd_en, w_addr, f_rd_en, f_addr, pe_win_st, pe_win,
                  pe_din, pe_input_rd_en, pe_featmap_size, pe_convlayer_state,
                  o_wr_en, o_addr, o_data});
  endfunction

  task automatic run_pass(input int idx, input bit poke);
    vec_t v;
    int wc = 0, wst = 0, fc = 0, ic = 0, oc = 0, em = 0, cs = 0, gaps = 0, bad = 0, lat = 0;
    int nsq, r;
    bit prev_f = 0, seen_f = 0, got_done = 0;
    logic [9:0] a;
    v   = vecs[idx];
    nsq = int'(v.n) * int'(v.n);
    r   = (v.n >= 5'd3) ? (int'(v.n) - 2) * (int'(v.n) - 2) : 0;
    featmap_size = v.n; w_base = v.wb; f_base = v.fb; o_base = v.ob;
    start = 1'b1;
    for (int s = 1; s <= 3000 && !got_done; s++) begin
      @(negedge clk);
      start = 1'b0;
      pe_dout_start = 1'b0;
      if (s == 1) begin
        check($sformatf("v%0d busy_first", idx), int'(busy), (v.exp_lat != 1) ? 1 : 0);
        check($sformatf("v%0d err_first", idx), int'(err), (v.exp_err && v.exp_lat == 1) ? 1 : 0);
        check($sformatf("v%0d fmsize", idx), int'(pe_featmap_size), int'(v.n));
      end
      if (w_rd_en) begin
        if (w_addr != v.wb + 10'(wc)) bad++;
        wc++;
      end
      if (pe_win_st) begin
        a = v.wb + 10'(wst);
        if (pe_win != ({6'd0, a} + 16'd1)) bad++;
        wst++;
      end
      if (f_rd_en) begin
        if (seen_f && !prev_f) gaps++;
        if (f_addr != v.fb + 10'(fc)) bad++;
        fc++;
        seen_f = 1'b1;
      end
      prev_f = f_rd_en;
      if (pe_input_rd_en) begin
        a = v.fb + 10'(ic);
        if (pe_din != (16'h4000 + {6'd0, a})) bad++;
        if (!pe_convlayer_state) bad++;
        ic++;
        if (ic > nsq - r && em < v.limit) begin
          pe_dout_start = 1'b1;
          pe_dout = 16'h8000 + 16'(em);
          em++;
        end
      end
      if (pe_convlayer_state) cs++;
      if (o_wr_en) begin
        if (o_addr != v.ob + 10'(oc)) bad++;
        if (o_data != 16'h8000 + 16'(oc)) bad++;
        oc++;
      end
      if (poke && s == 3) begin
        start = 1'b1;
        featmap_size = 5'd4;
      end
      if (done) begin
        got_done = 1'b1;
        lat = s;
      end
    end
    check($sformatf("v%0d done_seen", idx), int'(got_done), 1);
    check($sformatf("v%0d latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d busy_at_done", idx), int'(busy), 0);
    check($sformatf("v%0d err_at_done", idx), int'(err), int'(v.exp_err));
    check($sformatf("v%0d fmsize_at_done", idx), int'(pe_featmap_size), int'(v.n));
    check($sformatf("v%0d w_reads", idx), wc, v.exp_w);
    check($sformatf("v%0d win_st_cycles", idx), wst, v.exp_w);
    check($sformatf("v%0d f_reads", idx), fc, v.exp_f);
    check($sformatf("v%0d in_rd_cycles", idx), ic, v.exp_f);
    check($sformatf("v%0d f_gaps", idx), gaps, 0);
    check($sformatf("v%0d writes", idx), oc, v.exp_wr);
    check($sformatf("v%0d conv_state_cycles", idx), cs, v.exp_cs);
    check($sformatf("v%0d addr_data_errs", idx), bad, 0);
    @(negedge clk);
    pe_dout_start = 1'b0;
    check($sformatf("v%0d post_done_quiet", idx), int'(|{done, o_wr_en, busy, w_rd_en, f_rd_en}), 0);
    $display("pass v%0d: N=%0d wreads=%0d freads=%0d writes=%0d err=%0b latency=%0d",
             idx, v.n, wc, fc, oc, err, lat);
  endtask

  initial begin
    int fc, wr, dn;
    for (int i = 0; i < 1024; i++) begin
      wmem[i] = 16'(i + 1);
      fmem[i] = 16'h4000 + 16'(i);
    end
    //          n      wb        fb        ob       lim  w  f    wr   err   lat  cs
    vecs[0] = '{5'd6,  10'd0,    10'd0,    10'd64,  16,  9, 36,  16,  1'b0, 47,  37};
    vecs[1] = '{5'd3,  10'd5,    10'd40,   10'd200, 1,   9, 9,   1,   1'b0, 20,  10};
    vecs[2] = '{5'd2,  10'd0,    10'd0,    10'd0,   0,   0, 0,   0,   1'b1, 1,   0};
    vecs[3] = '{5'd0,  10'd0,    10'd0,    10'd0,   0,   0, 0,   0,   1'b1, 1,   0};
    vecs[4] = '{5'd4,  10'd1020, 10'd1015, 10'd1022, 4,  9, 16,  4,   1'b0, 27,  17};
    vecs[5] = '{5'd6,  10'd0,    10'd0,    10'd64,  10,  9, 36,  10,  1'b1, 110, 100};
    vecs[6] = '{5'd31, 10'd0,    10'd100,  10'd300, 841, 9, 961, 841, 1'b0, 972, 962};

    rst = 1'b1; start = 1'b0; featmap_size = '0; w_base = '0; f_base = '0; o_base = '0;
    pe_dout = '0; pe_dout_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_or(), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs_or(), 0);

    for (int i = 0; i < 7; i++) run_pass(i, 1'b0);

    // Reset during STREAM at the 20th pixel read
    featmap_size = 5'd6; w_base = 10'd0; f_base = 10'd0; o_base = 10'd64;
    start = 1'b1;
    fc = 0;
    for (int s = 0; s < 200 && fc < 20; s++) begin
      @(negedge clk);
      start = 1'b0;
      if (f_rd_en) fc++;
    end
    check("mid_pass_reached_pixel20", fc, 20);
    rst = 1'b1;
    @(negedge clk);
    check("mid_pass_reset_outputs", outs_or(), 0);
    rst = 1'b0;
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("mid_pass_no_done", dn, 0);
    $display("seq reset_mid_stream: reads_before_reset=%0d", fc);
    run_pass(0, 1'b0);

    // Stray PE strobes in IDLE, then a start pulse during LOAD_W
    wr = 0;
    pe_dout = 16'hdead;
    pe_dout_start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (o_wr_en) wr++;
    end
    pe_dout_start = 1'b0;
    @(negedge clk);
    if (o_wr_en) wr++;
    check("idle_stray_writes", wr, 0);
    $display("seq stray_strobes: writes=%0d", wr);
    run_pass(0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
